// File: rtl/commit_sched_tpu.sv
// In-order commit scheduler: tracks issued slots through PEND/DONE and
// retires the oldest DONE slot once per cycle towards the hazard table.
module commit_sched_tpu #(
    parameter int DEPTH_BUFF = 16,
    parameter int WIDTH_BUFF = $clog2(DEPTH_BUFF)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Issue,
    input  logic [WIDTH_BUFF-1:0] I_Issue_No,
    input  logic                  I_Sel_Unit,
    input  logic                  I_Done_S,
    input  logic [WIDTH_BUFF-1:0] I_Done_S_No,
    input  logic                  I_Done_V,
    input  logic [WIDTH_BUFF-1:0] I_Done_V_No,
    input  logic                  I_Flush,
    output logic                  O_Req_Commit,
    output logic [WIDTH_BUFF-1:0] O_Commit_No,
    output logic                  O_Full,
    output logic                  O_Empty,
    output logic [WIDTH_BUFF:0]   O_Num,
    output logic                  O_Err
);

    typedef enum logic [1:0] {FREE = 2'd0, PEND = 2'd1, DONE = 2'd2} slot_st_e;

    slot_st_e [DEPTH_BUFF-1:0] st_q, st_d;
    logic [DEPTH_BUFF-1:0]     tag_q, tag_d;
    logic [WIDTH_BUFF-1:0]     head_q, head_d, tail_q, tail_d;
    logic [WIDTH_BUFF:0]       count_q, count_d;
    logic                      commit_q, commit_d;
    logic [WIDTH_BUFF-1:0]     commit_no_q, commit_no_d;
    logic                      err_q, err_d;

    logic full, do_commit, iss_ok, same_no, ds_ok, dv_ok;

    assign full = (count_q == (WIDTH_BUFF+1)'(DEPTH_BUFF));

    always_comb begin
        st_d        = st_q;
        tag_d       = tag_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        commit_d    = 1'b0;
        commit_no_d = commit_no_q;
        err_d       = err_q;

        // Everything below is judged on registered slot state, so a
        // completion for a slot issued in the same cycle sees it FREE.
        do_commit = (st_q[head_q] == DONE);
        iss_ok    = I_Issue & ~full & (I_Issue_No == tail_q);
        same_no   = I_Done_S & I_Done_V & (I_Done_S_No == I_Done_V_No);
        ds_ok     = I_Done_S & ~same_no & (st_q[I_Done_S_No] == PEND) & ~tag_q[I_Done_S_No];
        dv_ok     = I_Done_V & ~same_no & (st_q[I_Done_V_No] == PEND) &  tag_q[I_Done_V_No];

        if (ds_ok) st_d[I_Done_S_No] = DONE;
        if (dv_ok) st_d[I_Done_V_No] = DONE;

        if (do_commit) begin
            commit_d     = 1'b1;
            commit_no_d  = head_q;
            st_d[head_q] = FREE;
            head_d       = head_q + 1'b1;
        end

        // Accepted issue targets tail, never the committing head (full is dropped).
        if (iss_ok) begin
            st_d[tail_q]  = PEND;
            tag_d[tail_q] = I_Sel_Unit;
            tail_d        = tail_q + 1'b1;
        end

        count_d = count_q + (WIDTH_BUFF+1)'(iss_ok) - (WIDTH_BUFF+1)'(do_commit);
        err_d   = err_q | (I_Issue & ~iss_ok) | (I_Done_S & ~ds_ok) | (I_Done_V & ~dv_ok);

        if (I_Flush) begin
            for (int i = 0; i < DEPTH_BUFF; i++) st_d[i] = FREE;
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            commit_d    = 1'b0;
            commit_no_d = commit_no_q;
            err_d       = err_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_BUFF; i++) st_q[i] <= FREE;
            tag_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            commit_q    <= 1'b0;
            commit_no_q <= '0;
            err_q       <= 1'b0;
        end else begin
            st_q        <= st_d;
            tag_q       <= tag_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            commit_q    <= commit_d;
            commit_no_q <= commit_no_d;
            err_q       <= err_d;
        end
    end

    assign O_Req_Commit = commit_q;
    assign O_Commit_No  = commit_no_q;
    assign O_Full       = full;
    assign O_Empty      = (count_q == '0);
    assign O_Num        = count_q;
    assign O_Err        = err_q;

endmodule
